// File: rtl/key_entry_buffer_pkg.sv
// Shared constants, key classes and the debounce FSM state type for the
// keypad entry path (keypad_scan -> key_entry_buffer -> scan_ctl).
package key_entry_buffer_pkg;

    localparam int KEYPAD_W         = 4;
    localparam int FTSD_W           = 4;
    localparam int KEY_ENTRY_DIGITS = 4;

    localparam logic [3:0] KEY_BLANK = 4'hF;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_BKSP  = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_HOLD,
        ST_RELEASE
    } key_state_t;

    typedef enum logic [1:0] {
        KC_DIGIT,
        KC_CLEAR,
        KC_BKSP,
        KC_IGNORE
    } key_class_t;

    function automatic key_class_t classify(input logic [KEYPAD_W-1:0] k);
        if (k <= 4'h9)           return KC_DIGIT;
        else if (k == KEY_CLEAR) return KC_CLEAR;
        else if (k == KEY_BKSP)  return KC_BKSP;
        else                     return KC_IGNORE;
    endfunction

endpackage

// File: rtl/key_stable_detect.sv
// Press/release debouncer: accepts a key after STABLE_CNT identical enabled
// samples and re-arms only after STABLE_CNT consecutive released samples.
module key_stable_detect
    import key_entry_buffer_pkg::*;
#(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [KEYPAD_W-1:0] key,
    input  logic                pressed,
    output logic                accept,
    output logic [KEYPAD_W-1:0] accept_code
);

    localparam logic [CNT_W:0] STABLE_LIM = (CNT_W+1)'(STABLE_CNT);

    key_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [KEYPAD_W-1:0] cand;
    logic [CNT_W:0]      cnt_nxt;
    logic                cnt_done;

    // Done is judged on the count this sample would produce, so the
    // strobe lines up with the edge that reaches STABLE_CNT.
    assign cnt_nxt     = {1'b0, cnt} + 1'b1;
    assign cnt_done    = (cnt_nxt >= STABLE_LIM);
    assign accept      = en && (state == ST_PRESS) && pressed && (key == cand) && cnt_done;
    assign accept_code = cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else if (en) begin
            case (state)
                ST_IDLE: begin
                    if (pressed) begin
                        cand  <= key;
                        cnt   <= CNT_W'(1);
                        state <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (!pressed) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else if (key != cand) begin
                        cand <= key;
                        cnt  <= CNT_W'(1);
                    end else if (cnt_done) begin
                        cnt   <= '0;
                        state <= ST_HOLD;
                    end else begin
                        cnt <= cnt_nxt[CNT_W-1:0];
                    end
                end
                ST_HOLD: begin
                    if (!pressed) begin
                        cnt   <= CNT_W'(1);
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (pressed) begin
                        cnt   <= '0;
                        state <= ST_HOLD;
                    end else if (cnt_done) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt_nxt[CNT_W-1:0];
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_entry_buffer.sv
// Debounced 4-digit keypad entry register (digit / backspace / clear).
// Define KEY_ENTRY_BUFFER_OVERWRITE_EN to let digits shift in when full.
module key_entry_buffer
    import key_entry_buffer_pkg::*;
#(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [3:0]    key,
    input  logic          pressed,
    output logic [3:0]    digit0,
    output logic [3:0]    digit1,
    output logic [3:0]    digit2,
    output logic [3:0]    digit3,
    output logic [2:0]    count,
    output logic          key_valid,
    output logic [3:0]    key_code,
    output logic          full
);

    localparam logic [2:0] MAX_CNT = 3'(KEY_ENTRY_DIGITS);

    logic [KEY_ENTRY_DIGITS-1:0][FTSD_W-1:0] dig;
    logic                                    accept;
    logic [KEYPAD_W-1:0]                     acc_code;

    key_stable_detect #(
        .STABLE_CNT (STABLE_CNT),
        .CNT_W      (CNT_W)
    ) u_detect (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .key         (key),
        .pressed     (pressed),
        .accept      (accept),
        .accept_code (acc_code)
    );

    // dig[0] is the rightmost digit; new digits enter at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig       <= {KEY_ENTRY_DIGITS{KEY_BLANK}};
            count     <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= 1'b0;
            if (accept) begin
                case (classify(acc_code))
                    KC_DIGIT: begin
                        key_valid <= 1'b1;
                        key_code  <= acc_code;
                        if (count < MAX_CNT) begin
                            dig   <= {dig[KEY_ENTRY_DIGITS-2:0], acc_code};
                            count <= count + 3'd1;
                        end
`ifdef KEY_ENTRY_BUFFER_OVERWRITE_EN
                        else begin
                            dig <= {dig[KEY_ENTRY_DIGITS-2:0], acc_code};
                        end
`else
                        else begin
                            dig <= dig;
                        end
`endif
                    end
                    KC_BKSP: begin
                        key_valid <= 1'b1;
                        key_code  <= acc_code;
                        if (count != 3'd0) begin
                            dig   <= {KEY_BLANK, dig[KEY_ENTRY_DIGITS-1:1]};
                            count <= count - 3'd1;
                        end
                    end
                    KC_CLEAR: begin
                        key_valid <= 1'b1;
                        key_code  <= acc_code;
                        dig       <= {KEY_ENTRY_DIGITS{KEY_BLANK}};
                        count     <= '0;
                    end
                    default: begin
                        key_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign digit0 = dig[0];
    assign digit1 = dig[1];
    assign digit2 = dig[2];
    assign digit3 = dig[3];
    assign full   = (count == MAX_CNT);

endmodule

// File: tb/tb_key_entry_buffer.sv
// Bench for key_entry_buffer: directed scenarios plus randomized key traffic
// checked against a run-length debounce model and a digit queue.
module tb_key_entry_buffer;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       pressed = 1'b0;
    logic [3:0] key = 4'h0;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [2:0] count;
    logic       key_valid;
    logic [3:0] key_code;
    logic       full;

    key_entry_buffer #(.STABLE_CNT(S), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .key       (key),
        .pressed   (pressed),
        .digit0    (digit0),
        .digit1    (digit1),
        .digit2    (digit2),
        .digit3    (digit3),
        .count     (count),
        .key_valid (key_valid),
        .key_code  (key_code),
        .full      (full)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int kv_seen = 0;

    // Reference model: a keystroke fires when the debouncer is armed and the
    // current run of identical pressed samples reaches S; it re-arms after a
    // run of S released samples. Digits live in a queue, oldest first.
    int         q[$];
    bit         armed;
    int         press_run, rel_run, press_key;
    bit         exp_kv;
    logic [3:0] exp_code;

    task automatic model_reset();
        q.delete();
        armed = 1; press_run = 0; rel_run = 0; press_key = 0;
        exp_kv = 0; exp_code = 4'h0;
    endtask

    task automatic model_accept(int c);
        if (c <= 9) begin
            exp_kv = 1; exp_code = 4'(c);
            if (q.size() < 4) q.push_back(c);
            else begin
`ifdef KEY_ENTRY_BUFFER_OVERWRITE_EN
                void'(q.pop_front());
                q.push_back(c);
`endif
            end
        end else if (c == 12) begin
            exp_kv = 1; exp_code = 4'(c);
            q.delete();
        end else if (c == 13) begin
            exp_kv = 1; exp_code = 4'(c);
            if (q.size() > 0) void'(q.pop_back());
        end
    endtask

    task automatic model_step(bit r, bit e, bit p, int k);
        exp_kv = 0;
        if (r) model_reset();
        else if (e) begin
            if (p) begin
                rel_run = 0;
                if (press_run > 0 && k == press_key) press_run++;
                else begin press_key = k; press_run = 1; end
                if (armed && press_run >= S) begin
                    armed = 0;
                    model_accept(press_key);
                end
            end else begin
                press_run = 0;
                rel_run++;
                if (!armed && rel_run >= S) armed = 1;
            end
        end
    endtask

    function automatic logic [3:0] exp_digit(int i);
        if (i < q.size()) return 4'(q[q.size()-1-i]);
        return 4'hF;
    endfunction

    function automatic logic [24:0] exp_vec();
        return {exp_digit(3), exp_digit(2), exp_digit(1), exp_digit(0),
                3'(q.size()), (q.size() == 4), exp_kv, exp_code};
    endfunction

    logic [24:0] dut_vec;
    assign dut_vec = {digit3, digit2, digit1, digit0, count, full, key_valid, key_code};

    task automatic tick(bit r, bit e, bit p, logic [3:0] k);
        @(negedge clk);
        rst = r; en = e; pressed = p; key = k;
        @(posedge clk);
        #1;
        model_step(r, e, p, k);
        if (key_valid) kv_seen++;
    endtask

    task automatic keystroke(logic [3:0] k);
        repeat (S) tick(0, 1, 1, k);
        repeat (S) tick(0, 1, 0, k);
    endtask

    task automatic test_reset();
        tick(1, 1, 0, 4'h0);
        tests++;
        if (dut_vec !== {16'hFFFF, 3'd0, 1'b0, 1'b0, 4'h0}) begin
            fails++; $display("FAIL reset_values: got %h expected %h", dut_vec, {16'hFFFF, 3'd0, 1'b0, 1'b0, 4'h0});
        end
        tick(0, 0, 0, 4'h0);
    endtask

    task automatic test_single_key();
        kv_seen = 0;
        for (int i = 0; i < S; i++) begin
            tick(0, 1, 1, 4'h5);
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL single_press_tick%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        for (int i = 0; i < S; i++) begin
            tick(0, 1, 0, 4'h5);
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL single_release_tick%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        tests++;
        if ({digit3, digit2, digit1, digit0, count, 6'(kv_seen)} !== {16'hFFF5, 3'd1, 6'd1}) begin
            fails++; $display("FAIL single_key: got %h/%0d/%0d expected FFF5/1/1",
                              {digit3, digit2, digit1, digit0}, count, kv_seen);
        end
    endtask

    task automatic test_fill();
        logic [15:0] want;
`ifdef KEY_ENTRY_BUFFER_OVERWRITE_EN
        want = 16'h2347;
`else
        want = 16'h1234;
`endif
        keystroke(4'hC);
        kv_seen = 0;
        keystroke(4'h1); keystroke(4'h2); keystroke(4'h3); keystroke(4'h4);
        tests++;
        if ({digit3, digit2, digit1, digit0, full} !== {16'h1234, 1'b1}) begin
            fails++; $display("FAIL fill_four: got %h full=%b expected 1234 full=1",
                              {digit3, digit2, digit1, digit0}, full);
        end
        keystroke(4'h7);
        tests++;
        if ({digit3, digit2, digit1, digit0, count, 6'(kv_seen)} !== {want, 3'd4, 6'd5}) begin
            fails++; $display("FAIL fill_fifth: got %h/%0d/%0d expected %h/4/5",
                              {digit3, digit2, digit1, digit0}, count, kv_seen, want);
        end
        tests++;
        if (dut_vec !== exp_vec()) begin
            fails++; $display("FAIL fill_model: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_bksp();
        keystroke(4'hC); keystroke(4'h2); keystroke(4'h9);
        keystroke(4'hD);
        tests++;
        if ({digit3, digit2, digit1, digit0, count} !== {16'hFFF2, 3'd1}) begin
            fails++; $display("FAIL bksp_shift: got %h/%0d expected FFF2/1", {digit3, digit2, digit1, digit0}, count);
        end
        keystroke(4'hD);
        kv_seen = 0;
        keystroke(4'hD);
        tests++;
        if ({digit3, digit2, digit1, digit0, count, key_code, 6'(kv_seen)} !== {16'hFFFF, 3'd0, 4'hD, 6'd1}) begin
            fails++; $display("FAIL bksp_empty: got %h/%0d code=%h pulses=%0d expected FFFF/0 code=d pulses=1",
                              {digit3, digit2, digit1, digit0}, count, key_code, kv_seen);
        end
    endtask

    task automatic test_clear_and_ignored();
        keystroke(4'h1); keystroke(4'h2); keystroke(4'h3); keystroke(4'h4);
        kv_seen = 0;
        keystroke(4'hA); keystroke(4'hE);
        tests++;
        if ({digit3, digit2, digit1, digit0, key_code, 6'(kv_seen)} !== {16'h1234, 4'h4, 6'd0}) begin
            fails++; $display("FAIL ignored_keys: got %h code=%h pulses=%0d expected 1234 code=4 pulses=0",
                              {digit3, digit2, digit1, digit0}, key_code, kv_seen);
        end
        keystroke(4'hC);
        tests++;
        if ({digit3, digit2, digit1, digit0, count, full} !== {16'hFFFF, 3'd0, 1'b0}) begin
            fails++; $display("FAIL clear: got %h/%0d full=%b expected FFFF/0 full=0",
                              {digit3, digit2, digit1, digit0}, count, full);
        end
    endtask

    task automatic test_bounce();
        kv_seen = 0;
        tick(0, 1, 1, 4'h3); tick(0, 1, 0, 4'h3); tick(0, 1, 1, 4'h3);
        repeat (S + 1) tick(0, 1, 1, 4'h3);
        repeat (S) tick(0, 1, 0, 4'h3);
        tests++;
        if ({digit0, count, 6'(kv_seen)} !== {4'h3, 3'd1, 6'd1}) begin
            fails++; $display("FAIL bounce: got d0=%h cnt=%0d pulses=%0d expected 3/1/1", digit0, count, kv_seen);
        end
        kv_seen = 0;
        tick(0, 1, 1, 4'h5); tick(0, 1, 1, 4'h5);
        repeat (S) tick(0, 1, 1, 4'h6);
        repeat (S) tick(0, 1, 0, 4'h6);
        tests++;
        if ({digit1, digit0, key_code, 6'(kv_seen)} !== {4'h3, 4'h6, 4'h6, 6'd1}) begin
            fails++; $display("FAIL key_change: got d1=%h d0=%h code=%h pulses=%0d expected 3/6/6/1",
                              digit1, digit0, key_code, kv_seen);
        end
    endtask

    task automatic test_en_gating();
        for (int i = 0; i < 4 * S; i++) begin
            tick(0, i[0], (i < 2 * S), 4'h2);
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL en_gating_tick%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_rst_mid_hold();
        repeat (S + 2) tick(0, 1, 1, 4'h8);
        tick(1, 1, 1, 4'h8);
        tests++;
        if (dut_vec !== {16'hFFFF, 3'd0, 1'b0, 1'b0, 4'h0}) begin
            fails++; $display("FAIL rst_mid_hold: got %h expected %h", dut_vec, {16'hFFFF, 3'd0, 1'b0, 1'b0, 4'h0});
        end
        repeat (S) tick(0, 1, 1, 4'h8);
        tests++;
        if ({digit3, digit2, digit1, digit0, count, key_valid, key_code} !== {16'hFFF8, 3'd1, 1'b1, 4'h8}) begin
            fails++; $display("FAIL rst_reaccept: got %h/%0d kv=%b code=%h expected FFF8/1 kv=1 code=8",
                              {digit3, digit2, digit1, digit0}, count, key_valid, key_code);
        end
        repeat (S) tick(0, 1, 0, 4'h8);
    endtask

    task automatic test_random();
        int errs = 0;
        for (int seg = 0; seg < 120; seg++) begin
            logic [3:0] k = 4'($urandom_range(0, 15));
            int hold = $urandom_range(1, 7);
            int rel  = $urandom_range(1, 7);
            for (int i = 0; i < hold + rel; i++) begin
                bit r = ($urandom_range(0, 299) == 0);
                bit e = ($urandom_range(0, 3) != 0);
                if (i < hold && $urandom_range(0, 5) == 0) k = 4'($urandom_range(0, 15));
                tick(r, e, (i < hold), k);
                tests++;
                if (dut_vec !== exp_vec()) begin
                    fails++; errs++;
                    if (errs <= 10)
                        $display("FAIL random_seg%0d_tick%0d: got %h expected %h", seg, i, dut_vec, exp_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_key();
        test_fill();
        test_bksp();
        test_clear_and_ignored();
        test_bounce();
        test_en_gating();
        test_rst_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
